// File: rtl/key_debounce5_pkg.sv
// Shared definitions for the five-channel key debouncer: FSM encoding,
// channel count and default timing parameters.
package key_debounce_defs;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

    localparam int NUM_KEYS            = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;  // 20 ms at 50 MHz
    localparam int DEF_CNT_W           = 20;

endpackage : key_debounce_defs

// File: rtl/key_debounce5_if.sv
// Key bus between the raw switch inputs and the debounced level/event outputs.
interface key_debounce5_if;
    import key_debounce_defs::*;

    logic [NUM_KEYS-1:0] i_key;
    logic [NUM_KEYS-1:0] o_key;
    logic [NUM_KEYS-1:0] o_rise;
    logic [NUM_KEYS-1:0] o_fall;
    logic                o_stable;

    modport master (
        output i_key,
        input  o_key,
        input  o_rise,
        input  o_fall,
        input  o_stable
    );

    modport slave (
        input  i_key,
        output o_key,
        output o_rise,
        output o_fall,
        output o_stable
    );

endinterface : key_debounce5_if

// File: rtl/key_debounce5_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, STABLE/PENDING FSM with a hold
// counter, registered level and single-cycle rise/fall pulses.
module debounce_ch
    import key_debounce_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_key,
    output logic o_rise,
    output logic o_fall,
    output logic o_stable_next
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key;
    logic             r_rise;
    logic             r_fall;

    deb_state_t       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_key_next;
    logic             w_rise_next;
    logic             w_fall_next;
    logic             w_mismatch;

    assign w_mismatch = r_s2 ^ r_key;

    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_key_next   = r_key;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;

        case (r_state)
            ST_STABLE: begin
                if (w_mismatch) begin
                    w_state_next = ST_PENDING;
                    w_cnt_next   = CNT_W'(1);
                end else begin
                    w_cnt_next   = '0;
                end
            end
            ST_PENDING: begin
                if (!w_mismatch) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == LAST_CNT) begin
                    // The mismatch has now lasted DEBOUNCE_CYCLES clocks: accept it.
                    w_key_next   = r_s2;
                    w_rise_next  = r_s2;
                    w_fall_next  = ~r_s2;
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_STABLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, which the two synchronizer stages depend on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_key   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_key;
            r_s2    <= r_s1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_key   <= w_key_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    assign o_key         = r_key;
    assign o_rise        = r_rise;
    assign o_fall        = r_fall;
    assign o_stable_next = (w_state_next == ST_STABLE);

endmodule : debounce_ch

// File: rtl/key_debounce5.sv
// Five independent debounce channels feeding gate_beh i_a..i_e (bit0..bit4),
// plus a registered all-channels-stable flag.
module key_debounce5
    import key_debounce_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    key_debounce5_if.slave  bus
);

    logic [NUM_KEYS-1:0] w_key;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_fall;
    logic [NUM_KEYS-1:0] w_stable_next;
    logic                r_stable;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_key         (bus.i_key[g]),
            .o_key         (w_key[g]),
            .o_rise        (w_rise[g]),
            .o_fall        (w_fall[g]),
            .o_stable_next (w_stable_next[g])
        );
    end

    // Built from next-state flags so the flag lines up with the FSM registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stable <= 1'b1;
        end else begin
            r_stable <= &w_stable_next;
        end
    end

    assign bus.o_key    = w_key;
    assign bus.o_rise   = w_rise;
    assign bus.o_fall   = w_fall;
    assign bus.o_stable = r_stable;

endmodule : key_debounce5

// File: doc/key_debounce5.md
Name: key_debounce5

Overview:
- Five-channel input conditioner that drives the five data inputs (i_a..i_e) of the downstream gate_beh combinational stage from raw, bouncy, asynchronous board switches/keys.
- Each channel has a 2-flop synchronizer followed by a debounce FSM with a hold counter.
- Outputs are a clean level per channel plus single-cycle rise/fall event pulses.
- Channel mapping: bit0→i_a, bit1→i_b, bit2→i_c, bit3→i_d, bit4→i_e.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive mismatch cycles required before a level change is accepted (20 ms at 50 MHz); legal range ≥2.
- CNT_W, 20, counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_key  input  5  raw asynchronous key levels.
- o_key  output  5  debounced levels; to gate_beh i_a..i_e.
- o_rise  output  5  one-cycle pulse when o_key bit goes 0→1.
- o_fall  output  5  one-cycle pulse when o_key bit goes 1→0.
- o_stable  output  1  high when all five channels are in STABLE state.

Behaviour:
- One clock; reset is synchronous and active-high; i_clk/i_rst as named above.
- Reset values:
  - sync flops 0; o_key 0; o_rise 0; o_fall 0.
  - all FSMs STABLE; all counters 0.
  - o_stable 1 on the first cycle after reset release.
- Synchronizer: s1 <= i_key; s2 <= s1. Only s2 is used downstream; no combinational path from i_key to any output.
- Per-channel FSM, 2 states:
  - STABLE:
    - if s2 == o_key bit: stay, cnt = 0.
    - if s2 != o_key bit: go PENDING, cnt <= 1.
  - PENDING:
    - if s2 == o_key bit (bounce back): go STABLE, cnt <= 0, o_key unchanged.
    - else if cnt == DEBOUNCE_CYCLES-1: o_key bit <= s2, pulse o_rise/o_fall in the same cycle o_key changes, go STABLE, cnt <= 0.
    - else cnt <= cnt + 1.
- Acceptance requires exactly DEBOUNCE_CYCLES consecutive clocks with s2 != o_key bit.
- Latency: a clean step on i_key, first sampled by edge E0, appears on o_key at edge E0 + 1 + DEBOUNCE_CYCLES (2 sync edges, overlapping with the first count cycle). o_rise/o_fall are asserted exactly on that edge and deassert on the next.
- Registered outputs: o_rise/o_fall are registered, high for exactly one cycle per accepted transition, never both high on the same bit.
- o_stable: registered AND of all channels being in STABLE (next-state based, so it aligns with FSM state).
- Counter arithmetic: unsigned CNT_W bits; never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Boundary conditions:
  - Channels are fully independent. Simultaneous transitions on several bits are accepted in the same cycle, with multiple o_rise/o_fall bits high together.
  - A bounce on the final count cycle (s2 returns to o_key value exactly when cnt == DEBOUNCE_CYCLES-1) is rejected: no change.
  - i_rst asserted mid-PENDING: next edge returns to reset values; no pulse is emitted; any key held during reset re-debounces from scratch after release.
  - An i_key glitch shorter than one clock may or may not be captured; if captured, it lasts ≤1–2 cycles of mismatch and is rejected.

Decomposition:
- Shared package/header `key_debounce_defs`: state encodings ST_STABLE=1'b0, ST_PENDING=1'b1; default DEBOUNCE_CYCLES; channel count NUM_KEYS=5.
- Sub-module `debounce_ch`, instantiated 5×:
  - contains sync flops, FSM, counter, level and pulse outputs, and a state-is-stable flag.
  - parameters DEBOUNCE_CYCLES, CNT_W.
- Top: generate loop over 5 instances plus the o_stable AND register.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: assert i_rst for 3 cycles with i_key=5'b11111 → during reset o_key=0, o_rise=0, o_fall=0. After release, o_key becomes 5'b11111 at release+6 edges with o_rise=5'b11111 for one cycle. o_stable is low during those counting cycles, then 1.
- Clean step: i_key[0] 0→1 held → o_key[0]=1 exactly 5 edges after first sampling edge. o_rise[0]=1 for one cycle, o_fall=0. o_key[4:1] unchanged.
- Bounce rejection: i_key[2] =1 for 3 cycles, then 0, repeated 5 times → o_key[2] stays 0, no pulses. Counter returns to 0 each time.
- Boundary: mismatch held for 3 cycles, then a 1-cycle return, then held for 4 cycles → accepted only after the final 4-cycle run. Exactly one o_rise[2] pulse.
- Simultaneous fall: o_key=5'b10101, i_key→5'b00000 on the same edge → o_key[4], o_key[2], o_key[0] all fall on the same edge. o_fall=5'b10101 for one cycle.
- Reset mid-operation: i_key[3] 0→1, i_rst pulsed after 2 count cycles → no o_rise[3] pulse. After release, o_key[3] rises 6 edges later with exactly one o_rise[3] pulse.
